// File: rtl/crc_arbiter.sv
// -----------------------------------------------------------------------------
// crc_arbiter
//
// Round-robin front end that time-shares one bit-serial CRC32 engine
// (poly 0x04C11DB7, MSB first, zero init) between NUM_REQ requesters.
// One 32-bit message is accepted at a time. The FSM walks the engine through
// LOAD (clear/load strobe), ENG_LATENCY compute cycles and CAPTURE. It then
// presents the remainder together with the owner's index on a valid/ready
// response port.
//
// Ports
//   clk_i          clock, all state on the rising edge
//   rst_i          asynchronous, active-low reset
//   req_valid_i    per-requester request valid
//   req_data_i     packed messages, requester k on [32k+31:32k]
//   req_ready_o    one-hot grant, only ever non-zero in IDLE
//   resp_valid_o   result valid (held until resp_ready_i)
//   resp_data_o    CRC remainder
//   resp_id_o      index of the requester owning the result
//   resp_ready_i   consumer accepts the result
//   eng_clr_no     registered active-low engine clear/load strobe
//   eng_compute_o  registered engine compute enable
//   eng_message_o  registered message held toward the engine
//   eng_result_i   engine remainder
//   busy_o         high in every state except IDLE
//
// Build option
//   CRC_ARB_XOROUT_EN : when defined, the captured result is inverted
//                       (eng_result_i ^ 32'hFFFFFFFF); latency is unchanged.
// -----------------------------------------------------------------------------
module crc_arbiter #(
  parameter  int NUM_REQ     = 4,
  parameter  int ENG_LATENCY = 32,
  localparam int IDW         = $clog2(NUM_REQ)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [32*NUM_REQ-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic                   resp_valid_o,
  output logic [31:0]            resp_data_o,
  output logic [IDW-1:0]         resp_id_o,
  input  logic                   resp_ready_i,
  output logic                   eng_clr_no,
  output logic                   eng_compute_o,
  output logic [31:0]            eng_message_o,
  input  logic [31:0]            eng_result_i,
  output logic                   busy_o
);

  // One extra bit so rr_ptr + offset cannot overflow before the wrap.
  localparam int         CW       = IDW + 1;
  localparam logic [5:0] CNT_LOAD = 6'(ENG_LATENCY - 1);

`ifdef CRC_ARB_XOROUT_EN
  localparam logic [31:0] XOR_OUT = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] XOR_OUT = 32'h0000_0000;
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t         state_reg,      state_next;
  logic [IDW-1:0] rr_ptr_reg,     rr_ptr_next;
  logic [5:0]     cnt_reg,        cnt_next;
  logic [31:0]    msg_reg,        msg_next;
  logic [IDW-1:0] id_reg,         id_next;
  logic [31:0]    data_reg,       data_next;
  logic           resp_valid_reg, resp_valid_next;
  logic           clr_n_reg,      clr_n_next;
  logic           compute_reg,    compute_next;

  logic [31:0]    req_words [NUM_REQ];
  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [CW-1:0]  cand;
  logic           accept;

  // ---------------------------------------------------------------------------
  // Unpack messages and drive the one-hot ready vector.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_words[gi]   = req_data_i[32*gi +: 32];
      assign req_ready_o[gi] = accept && (grant_idx == IDW'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Round-robin search: walk offsets from the highest down to zero, so the
  // last hit (the smallest offset from rr_ptr) wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr_reg} + CW'(i);
      if (cand >= CW'(NUM_REQ)) begin
        cand = cand - CW'(NUM_REQ);
      end
      if (req_valid_i[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  // Ready is combinational on req_valid_i; gating with rst_i keeps it low
  // while the reset is held, even though the state already reads IDLE.
  assign accept = (state_reg == S_IDLE) && grant_found && rst_i;

  // ---------------------------------------------------------------------------
  // Next-state and datapath.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    cnt_next    = cnt_reg;
    msg_next    = msg_reg;
    id_next     = id_reg;
    data_next   = data_reg;

    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next  = S_LOAD;
          msg_next    = req_words[grant_idx];
          id_next     = grant_idx;
          rr_ptr_next = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
        end
      end
      S_LOAD: begin
        state_next = S_COMPUTE;
        cnt_next   = CNT_LOAD;
      end
      S_COMPUTE: begin
        // The counter is loaded with ENG_LATENCY-1, so reaching zero marks
        // the final compute cycle.
        if (cnt_reg == 6'd0) begin
          state_next = S_CAPTURE;
        end else begin
          cnt_next = cnt_reg - 6'd1;
        end
      end
      S_CAPTURE: begin
        state_next = S_RESP;
        data_next  = eng_result_i ^ XOR_OUT;
      end
      S_RESP: begin
        if (resp_ready_i) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Engine controls and response valid are registered, so decode them from
    // the state being entered.
    clr_n_next      = (state_next != S_LOAD);
    compute_next    = (state_next == S_COMPUTE);
    resp_valid_next = (state_next == S_RESP);
  end

  // ---------------------------------------------------------------------------
  // State registers. clr_n resets low so the engine is held cleared while
  // the system is in reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg      <= S_IDLE;
      rr_ptr_reg     <= '0;
      cnt_reg        <= '0;
      msg_reg        <= '0;
      id_reg         <= '0;
      data_reg       <= '0;
      resp_valid_reg <= 1'b0;
      clr_n_reg      <= 1'b0;
      compute_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rr_ptr_reg     <= rr_ptr_next;
      cnt_reg        <= cnt_next;
      msg_reg        <= msg_next;
      id_reg         <= id_next;
      data_reg       <= data_next;
      resp_valid_reg <= resp_valid_next;
      clr_n_reg      <= clr_n_next;
      compute_reg    <= compute_next;
    end
  end

  assign resp_valid_o  = resp_valid_reg;
  assign resp_data_o   = data_reg;
  assign resp_id_o     = id_reg;
  assign eng_clr_no    = clr_n_reg;
  assign eng_compute_o = compute_reg;
  assign eng_message_o = msg_reg;
  assign busy_o        = (state_reg != S_IDLE);

endmodule

// File: tb/tb_crc_arbiter.sv
// -----------------------------------------------------------------------------
// tb_crc_arbiter
//
// Self-checking bench for crc_arbiter. It contains a behavioural bit-serial
// CRC32 engine for the DUT to drive, and a cycle-level reference model of the
// arbiter built from the job timeline (job age since acceptance). The CRC
// reference is computed by polynomial long division. It runs a directed
// vector table, hand sequences (backpressure, reset mid-compute, round-robin
// order) and a randomized phase.
// -----------------------------------------------------------------------------
module tb_crc_arbiter;

  localparam int N   = 4;
  localparam int L   = 32;
  localparam int IDW = 2;

`ifdef CRC_ARB_XOROUT_EN
  localparam logic [31:0] XO = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] XO = 32'h0000_0000;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [32*N-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              resp_valid;
  logic [31:0]       resp_data;
  logic [IDW-1:0]    resp_id;
  logic              resp_ready;
  logic              eng_clr_n;
  logic              eng_compute;
  logic [31:0]       eng_message;
  logic [31:0]       eng_result;
  logic              busy;

  always #5 clk = ~clk;

  crc_arbiter #(.NUM_REQ(N), .ENG_LATENCY(L)) dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .req_valid_i   (req_valid),
    .req_data_i    (req_data),
    .req_ready_o   (req_ready),
    .resp_valid_o  (resp_valid),
    .resp_data_o   (resp_data),
    .resp_id_o     (resp_id),
    .resp_ready_i  (resp_ready),
    .eng_clr_no    (eng_clr_n),
    .eng_compute_o (eng_compute),
    .eng_message_o (eng_message),
    .eng_result_i  (eng_result),
    .busy_o        (busy)
  );

  // Behavioural bit-serial CRC engine: clear/load on the strobe, one message
  // bit (MSB first) per compute cycle.
  logic [31:0] eng_crc, eng_sr;
  always @(posedge clk) begin
    if (!eng_clr_n) begin
      eng_crc <= 32'h0;
      eng_sr  <= eng_message;
    end else if (eng_compute) begin
      eng_crc <= {eng_crc[30:0], 1'b0} ^ ((eng_crc[31] ^ eng_sr[31]) ? 32'h04C11DB7 : 32'h0);
      eng_sr  <= {eng_sr[30:0], 1'b0};
    end
  end
  assign eng_result = eng_crc;

  // ---------------------------------------------------------------------------
  // Checking infrastructure
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Remainder of msg * x^32 divided by the CRC32 polynomial.
  function automatic logic [31:0] crc_ref(input logic [31:0] msg);
    logic [63:0] v;
    v = {msg, 32'h0};
    for (int i = 63; i >= 32; i--) begin
      if (v[i]) v = v ^ (64'h1_04C1_1DB7 << (i - 32));
    end
    return v[31:0] ^ XO;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_ready"},   req_ready,   '0);
    chk({tag, "_rvalid"},  resp_valid,  0);
    chk({tag, "_rdata"},   resp_data,   0);
    chk({tag, "_rid"},     resp_id,     0);
    chk({tag, "_clr_n"},   eng_clr_n,   0);
    chk({tag, "_compute"}, eng_compute, 0);
    chk({tag, "_msg"},     eng_message, 0);
    chk({tag, "_busy"},    busy,        0);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  bit          m_idle   = 1'b1;
  bit          post_rst = 1'b0;
  int          m_age, m_rr, m_id;
  logic [31:0] m_msg;
  bit          acc_now;
  int          acc_id_now;
  int          acc_cyc, rise_cyc, hs_cyc;
  bit          prev_rv;
  int          resp_cnt = 0;
  logic [31:0] last_data;
  int          last_id;
  int          acc_ids[$];
  int          acc_cycs[$];

  task automatic model_check();
    int g;
    int k;
    logic [N-1:0] exp_rdy;
    cyc++;
    acc_now = 1'b0;
    if (!rst_n) begin
      check_reset("rst");
      m_idle   = 1'b1;
      m_rr     = 0;
      prev_rv  = 1'b0;
      post_rst = 1'b1;
      return;
    end
    if (resp_valid && !prev_rv) rise_cyc = cyc;
    prev_rv = resp_valid;
    if (m_idle) begin
      g = -1;
      for (int i = 0; i < N; i++) begin
        k = (m_rr + i) % N;
        if (g < 0 && req_valid[k]) g = k;
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("idle_ready",   req_ready,   exp_rdy);
      chk("idle_busy",    busy,        0);
      chk("idle_rvalid",  resp_valid,  0);
      chk("idle_compute", eng_compute, 0);
      // Strobe still holds its reset value until the first edge after release.
      chk("idle_clr_n",   eng_clr_n,   post_rst ? 0 : 1);
      if (g >= 0) begin
        m_idle     = 1'b0;
        m_age      = 0;
        m_id       = g;
        m_msg      = req_data[32*g +: 32];
        m_rr       = (g + 1) % N;
        acc_now    = 1'b1;
        acc_id_now = g;
        acc_cyc    = cyc;
        acc_ids.push_back(g);
        acc_cycs.push_back(cyc);
        $display("ACCEPT cyc=%0d id=%0d msg=%08h", cyc, g, m_msg);
      end
    end else begin
      m_age++;
      chk("busy_busy",    busy,        1);
      chk("busy_ready",   req_ready,   '0);
      chk("busy_clr_n",   eng_clr_n,   (m_age == 1) ? 0 : 1);
      chk("busy_compute", eng_compute, (m_age >= 2 && m_age <= L + 1) ? 1 : 0);
      if (m_age <= L + 2) begin
        chk("eng_msg_stable", eng_message, m_msg);
        chk("early_rvalid",   resp_valid,  0);
      end else begin
        chk("resp_valid", resp_valid, 1);
        chk("resp_data",  resp_data,  crc_ref(m_msg));
        chk("resp_id",    resp_id,    m_id);
        if (resp_ready) begin
          $display("RESP   cyc=%0d id=%0d crc=%08h", cyc, resp_id, resp_data);
          m_idle    = 1'b1;
          hs_cyc    = cyc;
          last_data = resp_data;
          last_id   = int'(resp_id);
          resp_cnt++;
        end
      end
    end
    post_rst = 1'b0;
  endtask

  // Sample on the falling edge, return just after the next rising edge so
  // inputs can be changed safely.
  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_msg();
    case ($urandom % 4)
      0:       return 32'h1 << ($urandom % 32);
      1:       return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_accept(input string nm);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      step();
      if (acc_now) got = 1'b1;
    end
    chk({nm, "_accept_timeout"}, got, 1);
  endtask

  task automatic wait_resp(input string nm);
    int start;
    start = resp_cnt;
    for (int n = 0; n < 200 && resp_cnt == start; n++) step();
    chk({nm, "_resp_timeout"}, resp_cnt, start + 1);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    int          id;
    logic [31:0] msg;
    logic [31:0] exp_crc;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int start;
    int d;
    bit got;

    vecs[0] = '{0, 32'h0000_0001, 32'h04C1_1DB7};
    vecs[1] = '{2, 32'h0000_0000, 32'h0000_0000};
    vecs[2] = '{1, 32'h0000_0002, 32'h0982_3B6E};
    vecs[3] = '{3, 32'h0000_0003, 32'h0D43_26D9};
    vecs[4] = '{0, 32'h0000_0040, 32'h3486_7077};
    vecs[5] = '{2, 32'h0000_0020, 32'h9823_B6E0};

    rst_n      = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    resp_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;

    // --- table-driven single jobs -------------------------------------------
    for (int v = 0; v < 6; v++) begin
      req_valid               = '0;
      req_valid[vecs[v].id]   = 1'b1;
      req_data[32*vecs[v].id +: 32] = vecs[v].msg;
      resp_ready = 1'b1;
      wait_accept("tbl");
      req_valid = '0;
      wait_resp("tbl");
      chk("tbl_data",    last_data, vecs[v].exp_crc ^ XO);
      chk("tbl_id",      last_id,   vecs[v].id);
      chk("tbl_latency", rise_cyc - acc_cyc, 35);
    end

    // --- backpressure ---------------------------------------------------------
    resp_ready       = 1'b0;
    req_valid        = '0;
    req_valid[1]     = 1'b1;
    req_data[32 +: 32] = 32'h0000_0003;
    wait_accept("bp");
    req_valid = '0;
    got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      step();
      if (resp_valid) got = 1'b1;
    end
    chk("bp_rise_timeout", got, 1);
    req_valid[3]        = 1'b1;
    req_data[96 +: 32]  = 32'hDEAD_BEEF;
    for (int n = 0; n < 10; n++) begin
      step();
      chk("bp_hold_data",  resp_data,  32'h0D43_26D9 ^ XO);
      chk("bp_hold_id",    resp_id,    1);
      chk("bp_hold_valid", resp_valid, 1);
      chk("bp_ready_low",  req_ready,  '0);
    end
    resp_ready = 1'b1;
    start = resp_cnt;
    step();
    chk("bp_handshake", resp_cnt, start + 1);
    step();
    chk("bp_next_grant_cyc", acc_cyc, hs_cyc + 1);
    chk("bp_next_grant_id",  acc_id_now, 3);
    req_valid = '0;
    wait_resp("bp");
    chk("bp_next_data", last_data, crc_ref(32'hDEAD_BEEF));

    // --- reset in the middle of COMPUTE ----------------------------------------
    req_valid          = '0;
    req_valid[2]       = 1'b1;
    req_data[64 +: 32] = 32'h1234_5678;
    wait_accept("mr");
    for (int n = 0; n < 100 && !(!m_idle && m_age == 10); n++) step();
    chk("mr_reach_compute10", m_age, 10);
    rst_n = 1'b0;
    #1;
    check_reset("mr_now");
    repeat (3) step();
    start = resp_cnt;

    // --- round-robin with all requesters held valid -----------------------------
    acc_ids.delete();
    acc_cycs.delete();
    req_valid = '1;
    for (int k = 0; k < N; k++) req_data[32*k +: 32] = $urandom;
    rst_n = 1'b1;
    for (int n = 0; n < 400 && acc_ids.size() < 5; n++) begin
      step();
      if (acc_now) req_data[32*acc_id_now +: 32] = $urandom;
    end
    chk("rr_count", acc_ids.size(), 5);
    if (acc_ids.size() == 5) begin
      for (int i = 0; i < 5; i++) chk("rr_order", acc_ids[i], i % N);
      for (int i = 1; i < 5; i++) begin
        d = acc_cycs[i] - acc_cycs[i-1];
        chk("rr_spacing", d, 36);
      end
    end
    chk("rr_resp_count", resp_cnt - start, 4);

    // --- randomized traffic ------------------------------------------------------
    for (int n = 0; n < 3000; n++) begin
      step();
      resp_ready = ($urandom % 4) != 0;
      for (int k = 0; k < N; k++) begin
        if (acc_now && acc_id_now == k) begin
          req_valid[k]         = 1'($urandom % 2);
          req_data[32*k +: 32] = rnd_msg();
        end else if (!req_valid[k]) begin
          if ($urandom % 4 == 0) begin
            req_valid[k]         = 1'b1;
            req_data[32*k +: 32] = rnd_msg();
          end
        end else if ($urandom % 64 == 0) begin
          req_valid[k] = 1'b0;
        end
      end
    end

    // --- drain -----------------------------------------------------------------------
    req_valid  = '0;
    resp_ready = 1'b1;
    for (int n = 0; n < 200 && !m_idle; n++) step();
    chk("drain_idle", m_idle, 1);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc_arbiter.md
# crc_arbiter

Round-robin controller that shares one bit-serial CRC32 engine (polynomial 0x04C11DB7, no reflection, zero init) between NUM_REQ requesters. It accepts one 32-bit message at a time over a valid/ready handshake and sequences the engine through clear/load, a fixed number of compute cycles and result capture. It then returns the remainder with the requester ID over a valid/ready response port. It sits between the requesting masters and the CRC engine instance.

## Interface
- NUM_REQ, 4: number of requesters; range 2..16.
- ENG_LATENCY, 32: number of consecutive cycles eng_compute_o is held high per job; range 1..63.
- IDW, $clog2(NUM_REQ): response ID width (derived, not overridden).

- clk_i  in  1  clock; all state on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_data_i  in  32*NUM_REQ  message; requester k uses bits [32k+31:32k].
- req_ready_o  out  NUM_REQ  one-hot grant/ready.
- resp_valid_o  out  1  result valid.
- resp_data_o  out  32  CRC remainder.
- resp_id_o  out  IDW  index of the requester that owns the result.
- resp_ready_i  in  1  consumer accepts the result.
- eng_clr_no  out  1  registered, active-low engine clear/load strobe.
- eng_compute_o  out  1  registered engine compute enable.
- eng_message_o  out  32  registered message held stable toward the engine.
- eng_result_i  in  32  engine remainder output.
- busy_o  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE → LOAD → COMPUTE → CAPTURE → RESP → IDLE.
- **IDLE**
  - req_ready_o is one-hot on the granted index. The grant is the first index with req_valid_i high, searching upward (with wrap) from rr_ptr.
  - req_ready_o may depend combinationally on req_valid_i.
  - If no request is valid, req_ready_o is 0.
  - On the handshake, the FSM latches the message into eng_message_o and the index into resp_id_o, sets rr_ptr to grant+1 (mod NUM_REQ), and moves to LOAD.
- **LOAD**
  - eng_clr_no is low for exactly this one cycle.
  - eng_compute_o is 0.
- **COMPUTE**
  - eng_compute_o is high for exactly ENG_LATENCY cycles, tracked by a 6-bit down-counter.
  - The FSM leaves this state when the counter reaches its terminal value.
- **CAPTURE**
  - eng_compute_o is 0.
  - eng_result_i is registered into resp_data_o at the end of this cycle.
- **RESP**
  - resp_valid_o is high and is held with stable data and ID until resp_ready_i is high.
  - On the handshake, the FSM returns to IDLE.
- req_ready_o is 0 in all states except IDLE. Requests that arrive while busy wait without loss; requesters must hold valid and data.
- rr_ptr only advances on an accepted request.
- A request withdrawn before it is granted is legal. No fairness credit is kept.

## Timing
- **Reset values:**
  - state = IDLE, rr_ptr = 0.
  - req_ready_o = 0 (while rst_i is low).
  - resp_valid_o = 0, resp_data_o = 0, resp_id_o = 0.
  - eng_clr_no = 0, which holds the engine cleared during system reset.
  - eng_compute_o = 0, eng_message_o = 0, busy_o = 0.
- **Latency:** with acceptance at cycle t, LOAD is at t+1, COMPUTE spans t+2..t+1+ENG_LATENCY, and CAPTURE is at t+2+ENG_LATENCY. resp_valid_o first rises at t+3+ENG_LATENCY, which is cycle 35 for the default.
- **Throughput:** one job per ENG_LATENCY+4 cycles when resp_ready_i is tied high. IDLE always lasts at least one cycle between jobs.
- **Engine contract:** the engine's result is valid in the CAPTURE cycle, i.e. the first cycle after the final compute cycle. eng_message_o is stable from LOAD through CAPTURE.
- **Reset mid-operation:** rst_i low in any state aborts the job immediately and applies the reset values. The in-flight result is discarded and no response is issued.
- **Simultaneous events:** a response handshake and newly valid requests in the same cycle cause no acceptance in that cycle. The request is granted in the following IDLE cycle.

## Configuration
- CRC_ARB_XOROUT_EN:
  - When defined, the value captured in CAPTURE is eng_result_i ^ 32'hFFFFFFFF.
  - When undefined, the raw remainder is returned.
  - Latency is identical in both builds.

## Test plan
- **Single job:** requester 0 sends 0x00000001. resp_data_o = 0x04C11DB7 (0xFB3EE248 with XOROUT), resp_id_o = 0, resp_valid_o rising exactly 35 cycles after acceptance.
- **Zero message:** requester 2 sends 0x00000000. resp_data_o = 0x00000000 (0xFFFFFFFF with XOROUT), resp_id_o = 2.
- **Round-robin:** all 4 requesters held valid continuously. Grants follow the order 0,1,2,3,0, each response carries the matching ID, and acceptances are 36 cycles apart.
- **Backpressure:** resp_ready_i held low for 10 cycles after resp_valid_o rises. Data and ID stay stable, req_ready_o stays 0, and the next grant occurs in the cycle after the handshake.
- **Reset mid-compute:** rst_i asserted at COMPUTE cycle 10. All outputs take their reset values immediately, no response appears, and after release requester 0 is granted first.
- **Engine sequencing check:** for each job, eng_clr_no is low for exactly 1 cycle, eng_compute_o is high for exactly 32 consecutive cycles, and eng_message_o is unchanged from LOAD through CAPTURE.
